uart_tx_fifo: RTL and testbench

Parametrised successor to the single-word UART transmitter. Serialises DATA_WIDTH-bit words LSB-first with a runtime-programmable baud prescale, optional even/odd parity and 1 or 2 stop bits. A FIFO_DEPTH-word input buffer lets the producer queue words, and the block sends back-to-back frames with no idle gap. It sits between the system controller's data path and the serial line.

---
 rtl/uart_tx_fifo.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//
// Buffered UART transmitter. Words written by the producer are queued in a
// FIFO_DEPTH-entry circular buffer. Each word is sent LSB-first as one frame:
// a start bit, DATA_WIDTH data bits, an optional parity bit, then one or two
// stop bits. Each bit is held for P = max(Prescale,1) clock cycles. When a
// frame ends and another word is waiting, the next start bit follows the last
// stop cycle directly, with no idle gap.
//
// Prescale, parity and stop-bit settings are captured when a word is popped
// from the FIFO. Changing them mid-frame only affects later frames.
//
// Ports
//   CLK          system clock, rising edge
//   Reset        asynchronous, active-high; aborts any frame, empties FIFO
//   Prescale     clock cycles per serial bit (0 behaves as 1)
//   Parity_EN    1 = send a parity bit after the data bits
//   Parity_type  0 = even parity, 1 = odd parity
//   Stop_bits    0 = one stop bit, 1 = two stop bits
//   Data_valid   write strobe
//   Data         word to queue
//   Ready        FIFO not full
//   Busy         frame in progress or FIFO non-empty
//   Fifo_count   words waiting in the FIFO (the word in flight is excluded)
//   Tx_out       serial line, idles high
//   State_dbg    current FSM state encoding, for observation only
//
// Handshake (Data_valid / Ready): a word moves into the FIFO on a rising edge
// where Data_valid and Ready are both 1. Ready depends only on registered
// FIFO occupancy, never on Data_valid. The producer may hold Data_valid high
// across edges and must keep Data stable until the word is taken. A write
// offered while Ready is 0 is dropped, even if the transmitter pops a word on
// that same edge.
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DATA_WIDTH     = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                          CLK,
    input  logic                          Reset,
    input  logic [PRESCALE_WIDTH-1:0]     Prescale,
    input  logic                          Parity_EN,
    input  logic                          Parity_type,
    input  logic                          Stop_bits,
    input  logic                          Data_valid,
    input  logic [DATA_WIDTH-1:0]         Data,
    output logic                          Ready,
    output logic                          Busy,
    output logic [$clog2(FIFO_DEPTH):0]   Fifo_count,
    output logic                          Tx_out,
    output logic [2:0]                    State_dbg
);

    // -----------------------------------------------------------------------
    // Derived sizes
    // -----------------------------------------------------------------------
    localparam int AW = $clog2(FIFO_DEPTH);   // FIFO pointer width
    localparam int CW = AW + 1;               // occupancy width, holds 0..DEPTH
    localparam int BW = $clog2(DATA_WIDTH);   // data bit index width

    localparam logic [CW-1:0]             FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0]             LAST_BIT   = BW'(DATA_WIDTH - 1);
    localparam logic [PRESCALE_WIDTH-1:0] PRESC_ONE  = PRESCALE_WIDTH'(1);

    // -----------------------------------------------------------------------
    // FSM state encoding
    // -----------------------------------------------------------------------
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    // -----------------------------------------------------------------------
    // FIFO storage and pointers
    // -----------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q,  count_d;

    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head_word;

    // -----------------------------------------------------------------------
    // Transmitter registers
    // -----------------------------------------------------------------------
    logic [2:0]                state_q,    state_d;
    logic [DATA_WIDTH-1:0]     shift_q,    shift_d;
    logic [PRESCALE_WIDTH-1:0] presc_q,    presc_d;     // latched P, never 0
    logic [PRESCALE_WIDTH-1:0] cnt_q,      cnt_d;       // cycles left in bit
    logic [BW-1:0]             bit_idx_q,  bit_idx_d;
    logic                      stop_idx_q, stop_idx_d;  // 1 = second stop bit
    logic                      par_en_q,   par_en_d;
    logic                      par_bit_q,  par_bit_d;
    logic                      stop2_q,    stop2_d;
    logic                      tx_q,       tx_d;

    logic                      bit_done;
    logic [PRESCALE_WIDTH-1:0] eff_presc;
    logic [PRESCALE_WIDTH-1:0] cnt_reload;

    // -----------------------------------------------------------------------
    // FIFO control
    // -----------------------------------------------------------------------
    // A write is taken only when the FIFO was not full before the edge. A pop
    // on the same edge does not free a slot for that write.
    assign push      = Data_valid && (count_q != FULL_COUNT);
    assign head_word = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    // Storage needs no reset. Occupancy and pointers decide what is valid.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= Data;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // -----------------------------------------------------------------------
    // Bit timing
    // -----------------------------------------------------------------------
    // Prescale 0 is treated as 1, so the latched period is never zero. The
    // down-counter reloads to period-1 and a bit ends when the counter
    // reaches zero. The counter therefore never wraps.
    assign eff_presc  = (Prescale == '0) ? PRESC_ONE : Prescale;
    assign cnt_reload = presc_q - PRESC_ONE;
    assign bit_done   = (cnt_q == '0);

    // -----------------------------------------------------------------------
    // Transmit FSM next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        presc_d    = presc_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        stop2_d    = stop2_q;
        tx_d       = tx_q;
        pop        = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (count_q != '0) begin
                    pop = 1'b1;
                end
            end

            S_START: begin
                if (bit_done) begin
                    state_d   = S_DATA;
                    cnt_d     = cnt_reload;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end else begin
                    cnt_d = cnt_q - PRESC_ONE;
                end
            end

            S_DATA: begin
                if (bit_done) begin
                    cnt_d = cnt_reload;
                    if (bit_idx_q == LAST_BIT) begin
                        if (par_en_q) begin
                            state_d = S_PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d    = S_STOP;
                            stop_idx_d = 1'b0;
                            tx_d       = 1'b1;
                        end
                    end else begin
                        // Tx_out always shows shift_q[0]. The next bit
                        // is shift_q[1] before the shift takes effect.
                        bit_idx_d = bit_idx_q + BW'(1);
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - PRESC_ONE;
                end
            end

            S_PARITY: begin
                if (bit_done) begin
                    state_d    = S_STOP;
                    cnt_d      = cnt_reload;
                    stop_idx_d = 1'b0;
                    tx_d       = 1'b1;
                end else begin
                    cnt_d = cnt_q - PRESC_ONE;
                end
            end

            S_STOP: begin
                if (bit_done) begin
                    if (stop2_q && !stop_idx_q) begin
                        stop_idx_d = 1'b1;
                        cnt_d      = cnt_reload;
                    end else if (count_q != '0) begin
                        // Back-to-back: the next start bit begins on the same
                        // edge that ends this frame. The load is applied
                        // below.
                        pop = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - PRESC_ONE;
                end
            end

            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Frame load. This is shared by IDLE and by the end of STOP.
        // Configuration is captured here and held for the whole frame.
        // Parity is computed once from the popped word.
        if (pop) begin
            state_d   = S_START;
            shift_d   = head_word;
            presc_d   = eff_presc;
            cnt_d     = eff_presc - PRESC_ONE;
            par_en_d  = Parity_EN;
            par_bit_d = (^head_word) ^ Parity_type;
            stop2_d   = Stop_bits;
            tx_d      = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Transmit FSM registers
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            presc_q    <= PRESC_ONE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            presc_q    <= presc_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            stop2_q    <= stop2_d;
            tx_q       <= tx_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // All outputs come from registers only. No input reaches an output
    // through combinational logic.
    assign Tx_out     = tx_q;
    assign Ready      = (count_q != FULL_COUNT);
    assign Busy       = (state_q != S_IDLE) || (count_q != '0);
    assign Fifo_count = count_q;
    assign State_dbg  = state_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Directed bench for uart_tx_fifo. For each word it writes, the driver queues
// the expected serial frame: data byte, bit period, bit count and line bits.
// The parity bit is worked out by hand for each vector. A monitor watches
// Tx_out at every falling clock edge. When it sees a start bit, it pops the
// next expected frame and checks every line sample against it. A frame cut
// short by Reset is dropped without being scored. Other checks cover reset
// values, latency, Busy duration, FIFO full and overflow, Prescale 0, and
// asynchronous reset.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int PW    = 6;
    localparam int EW    = 48;   // {data[7:0], p[7:0], nbits[7:0], bits[23:0]}

    // -----------------------------------------------------------------------
    // Clock / reset
    // -----------------------------------------------------------------------
    logic          CLK   = 1'b0;
    logic          Reset = 1'b0;
    logic [PW-1:0] Prescale;
    logic          Parity_EN;
    logic          Parity_type;
    logic          Stop_bits;
    logic          Data_valid;
    logic [DW-1:0] Data;
    logic          Ready;
    logic          Busy;
    logic [2:0]    Fifo_count;
    logic          Tx_out;
    logic [2:0]    State_dbg;

    always #5 CLK = ~CLK;

    uart_tx_fifo #(
        .DATA_WIDTH     (DW),
        .FIFO_DEPTH     (DEPTH),
        .PRESCALE_WIDTH (PW)
    ) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .Prescale    (Prescale),
        .Parity_EN   (Parity_EN),
        .Parity_type (Parity_type),
        .Stop_bits   (Stop_bits),
        .Data_valid  (Data_valid),
        .Data        (Data),
        .Ready       (Ready),
        .Busy        (Busy),
        .Fifo_count  (Fifo_count),
        .Tx_out      (Tx_out),
        .State_dbg   (State_dbg)
    );

    // -----------------------------------------------------------------------
    // Scoreboard state
    // -----------------------------------------------------------------------
    int            n_vec = 0;
    int            n_err = 0;
    logic [EW-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Builds the expected line sequence from a hand-supplied parity bit.
    function automatic logic [EW-1:0] mk_exp(input logic [7:0] d, input int p,
                                             input logic pen, input logic pbit,
                                             input logic stop2);
        logic [23:0] b;
        int          n;
        b    = '0;
        n    = 0;
        b[n] = 1'b0;
        n++;
        for (int i = 0; i < 8; i++) begin
            b[n] = d[i];
            n++;
        end
        if (pen) begin
            b[n] = pbit;
            n++;
        end
        b[n] = 1'b1;
        n++;
        if (stop2) begin
            b[n] = 1'b1;
            n++;
        end
        return {d, 8'(p), 8'(n), b};
    endfunction

    // -----------------------------------------------------------------------
    // Driver tasks (called and returning just after a falling edge)
    // -----------------------------------------------------------------------
    task automatic put(input logic [7:0] d, input int p, input logic pen,
                       input logic pbit, input logic stop2);
        int guard;
        guard      = 0;
        Data       = d;
        Data_valid = 1'b1;
        while (!Ready && guard < 1000) begin
            @(negedge CLK);
            guard++;
        end
        if (!Ready) begin
            n_vec++;
            n_err++;
            $display("FAIL put_timeout: Ready stayed 0 for word 0x%02h, required 1", d);
            Data_valid = 1'b0;
            return;
        end
        @(posedge CLK);
        exp_q.push_back(mk_exp(d, p, pen, pbit, stop2));
        @(negedge CLK);
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (Busy && guard < 2000) begin
            @(negedge CLK);
            guard++;
        end
        if (Busy) begin
            n_vec++;
            n_err++;
            $display("FAIL idle_timeout: Busy still 1, required 0");
        end
    endtask

    // Counts Busy-high cycles from the first start-bit sample onwards.
    task automatic busy_len(input int exp_len, input string name);
        int guard;
        int n;
        guard = 0;
        n     = 0;
        while (Tx_out !== 1'b0 && guard < 200) begin
            @(negedge CLK);
            guard++;
        end
        while (Busy && n < 1000) begin
            n++;
            @(negedge CLK);
        end
        check(name, n, exp_len);
    endtask

    // -----------------------------------------------------------------------
    // Monitor: frame-level scoreboard on the serial line
    // -----------------------------------------------------------------------
    initial begin : monitor
        logic [EW-1:0] e;
        logic [23:0]   bits;
        logic [23:0]   got;
        logic [7:0]    d;
        int            nb;
        int            p;
        int            errs;
        int            guard;
        bit            aborted;
        forever begin
            @(negedge CLK);
            if (!Reset && Tx_out === 1'b0) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_frame: start bit at %0t, required none", $time);
                    guard = 0;
                    while (Tx_out !== 1'b1 && guard < 1000) begin
                        @(negedge CLK);
                        guard++;
                    end
                end else begin
                    e       = exp_q.pop_front();
                    d       = e[47:40];
                    p       = int'(e[39:32]);
                    nb      = int'(e[31:24]);
                    bits    = e[23:0];
                    errs    = 0;
                    got     = '0;
                    aborted = 1'b0;
                    for (int b = 0; b < nb; b++) begin
                        for (int c = 0; c < p; c++) begin
                            if (b != 0 || c != 0) @(negedge CLK);
                            if (Reset) begin
                                aborted = 1'b1;
                                break;
                            end
                            if (c == 0) got[b] = Tx_out;
                            if (Tx_out !== bits[b]) errs++;
                        end
                        if (aborted) break;
                    end
                    if (!aborted) begin
                        n_vec++;
                        if (errs != 0) begin
                            n_err++;
                            $display("FAIL frame_%02h: line bits %b (%0d bad samples), required %b",
                                     d, got, errs, bits);
                        end
                    end
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Watchdog
    // -----------------------------------------------------------------------
    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // -----------------------------------------------------------------------
    // Directed stimulus
    // -----------------------------------------------------------------------
    initial begin
        Data_valid  = 1'b0;
        Data        = '0;
        Prescale    = 6'd4;
        Parity_EN   = 1'b0;
        Parity_type = 1'b0;
        Stop_bits   = 1'b0;

        // Reset values
        #1 Reset = 1'b1;
        #2;
        check("rst_tx",    Tx_out,     1);
        check("rst_busy",  Busy,       0);
        check("rst_ready", Ready,      1);
        check("rst_count", Fifo_count, 0);
        repeat (3) @(negedge CLK);
        Reset = 1'b0;
        @(negedge CLK);

        // T1: 0x55, P=4, even parity (four ones -> 0), one stop
        Prescale  = 6'd4;
        Parity_EN = 1'b1;
        put(8'h55, 4, 1'b1, 1'b0, 1'b0);
        Data_valid = 1'b0;
        check("t1_busy_at_write", Busy,   1);
        check("t1_tx_before",     Tx_out, 1);
        @(negedge CLK);
        check("t1_tx_start",      Tx_out, 0);
        busy_len(44, "t1_busy_len");
        check("t1_tx_idle",       Tx_out, 1);

        // T2: 0xAA, P=2, odd parity (four ones -> 1), two stops.
        // Configuration is changed mid-frame and must not affect this frame.
        Prescale    = 6'd2;
        Parity_type = 1'b1;
        Stop_bits   = 1'b1;
        fork
            busy_len(24, "t2_busy_len");
            begin
                put(8'hAA, 2, 1'b1, 1'b1, 1'b1);
                Data_valid = 1'b0;
                repeat (3) @(negedge CLK);
                Prescale    = 6'd7;
                Parity_EN   = 1'b0;
                Parity_type = 1'b0;
                Stop_bits   = 1'b0;
            end
        join

        // T3: three back-to-back 10-cycle frames at P=1
        Prescale  = 6'd1;
        Parity_EN = 1'b0;
        Stop_bits = 1'b0;
        fork
            busy_len(30, "t3_busy_len");
            begin
                put(8'h01, 1, 1'b0, 1'b0, 1'b0);
                put(8'h80, 1, 1'b0, 1'b0, 1'b0);
                put(8'hFF, 1, 1'b0, 1'b0, 1'b0);
                Data_valid = 1'b0;
            end
        join

        // T4: fill the FIFO, then check overflow rejection and ordering
        Prescale = 6'd3;
        for (int i = 0; i < 5; i++) begin
            put(8'h10 + 8'(i), 3, 1'b0, 1'b0, 1'b0);
        end
        check("t4_ready_full", Ready,      0);
        check("t4_count_full", Fifo_count, 4);
        Data = 8'h15;
        @(negedge CLK);
        check("t4_ready_held", Ready,      0);
        check("t4_count_held", Fifo_count, 4);
        put(8'h15, 3, 1'b0, 1'b0, 1'b0);
        Data_valid = 1'b0;
        check("t4_count_after", Fifo_count, 4);
        wait_idle();

        // T5: Prescale 0 behaves as 1
        Prescale = 6'd0;
        fork
            busy_len(10, "t5_busy_len");
            begin
                put(8'h3C, 1, 1'b0, 1'b0, 1'b0);
                Data_valid = 1'b0;
            end
        join

        // T6: asynchronous reset during data bit 3, with one word queued
        Prescale    = 6'd4;
        Parity_EN   = 1'b1;
        Parity_type = 1'b0;
        put(8'hC3, 4, 1'b1, 1'b0, 1'b0);
        put(8'h3C, 4, 1'b1, 1'b0, 1'b0);
        Data_valid = 1'b0;
        check("t6_count_queued", Fifo_count, 1);
        repeat (16) @(negedge CLK);
        check("t6_bit3", Tx_out, 0);
        #2 Reset = 1'b1;
        #1;
        check("t6_rst_tx",    Tx_out,     1);
        check("t6_rst_busy",  Busy,       0);
        check("t6_rst_count", Fifo_count, 0);
        check("t6_rst_ready", Ready,      1);
        repeat (2) @(negedge CLK);
        #2 Reset = 1'b0;
        exp_q.delete();
        @(negedge CLK);
        Prescale = 6'd2;
        put(8'h5A, 2, 1'b1, 1'b0, 1'b0);
        Data_valid = 1'b0;
        wait_idle();

        repeat (5) @(negedge CLK);
        check("drain", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
